// File: rtl/mat_vec_sched_pkg.sv
// rtl/mat_vec_sched_pkg.sv - shared types and constants for the mat_vec_mul scheduler
package mat_vec_sched_pkg;

    localparam int MVM_LATENCY   = 5;
    localparam int DEF_DATAWIDTH = 18;
    localparam int DEF_FRACBITS  = 12;
    localparam int DEF_NREQ      = 2;
    localparam int DEF_TAGDEPTH  = 8;

    typedef logic [$clog2(DEF_NREQ)-1:0]       req_id_t;
    typedef logic signed [DEF_DATAWIDTH-1:0]   word_t;
    typedef word_t [3:0]                       vec4_t;
    typedef vec4_t [3:0]                       mat4_t;

    function automatic mat4_t identity_matrix();
        mat4_t m;
        m = '0;
        for (int r = 0; r < 4; r++) begin
            m[r][r] = word_t'(1 << DEF_FRACBITS);
        end
        return m;
    endfunction

endpackage

// File: rtl/mat_vec_mul.sv
// rtl/mat_vec_mul.sv - 4x4 fixed-point matrix-vector multiply, five enabled stages
// Stages: operand capture, products, pair sums, row sum, truncate; i_enable freezes all of them.
module mat_vec_mul
    import mat_vec_sched_pkg::*;
#(
    parameter int DATAWIDTH = 18,
    parameter int FRACBITS  = 12
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_enable,
    input  logic                              i_dv,
    input  logic [3:0][3:0][DATAWIDTH-1:0]    i_A,
    input  logic [3:0][DATAWIDTH-1:0]         i_x,
    output logic                              o_dv,
    output logic [3:0][DATAWIDTH-1:0]         o_y
);

    localparam int PW = 2 * DATAWIDTH;

    logic [MVM_LATENCY-1:0]            dv_q;
    logic [3:0][3:0][DATAWIDTH-1:0]    a_q;
    logic [3:0][DATAWIDTH-1:0]         x_q;
    logic [3:0][DATAWIDTH-1:0]         y_q;
    logic signed [PW-1:0]              prod_q [4][4];
    logic signed [PW:0]                psum_q [4][2];
    logic signed [PW+1:0]              sum_q  [4];
    logic                              unused_sum_bits;

    function automatic logic signed [PW-1:0] sx(input logic [DATAWIDTH-1:0] v);
        return {{DATAWIDTH{v[DATAWIDTH-1]}}, v};
    endfunction

    // Reset wins over the stall so a frozen pipeline still drains on rstn.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dv_q <= '0;
        end else if (i_enable) begin
            dv_q <= {dv_q[MVM_LATENCY-2:0], i_dv};
        end
    end

    always_ff @(posedge clk) begin
        if (i_enable) begin
            a_q <= i_A;
            x_q <= i_x;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    prod_q[r][c] <= sx(a_q[r][c]) * sx(x_q[c]);
                end
                psum_q[r][0] <= {prod_q[r][0][PW-1], prod_q[r][0]} + {prod_q[r][1][PW-1], prod_q[r][1]};
                psum_q[r][1] <= {prod_q[r][2][PW-1], prod_q[r][2]} + {prod_q[r][3][PW-1], prod_q[r][3]};
                sum_q[r]     <= {psum_q[r][0][PW], psum_q[r][0]} + {psum_q[r][1][PW], psum_q[r][1]};
                y_q[r]       <= {sum_q[r][PW+1], sum_q[r][DATAWIDTH+FRACBITS-2:FRACBITS]};
            end
        end
    end

    always_comb begin
        unused_sum_bits = 1'b0;
        for (int r = 0; r < 4; r++) begin
            unused_sum_bits = unused_sum_bits ^ (^sum_q[r]);
        end
    end

    assign o_dv = dv_q[MVM_LATENCY-1];
    assign o_y  = y_q;

endmodule

// File: rtl/mat_vec_sched_tag_fifo.sv
// rtl/mat_vec_sched_tag_fifo.sv - owner-tag FIFO tracking in-flight mat_vec_mul transactions
module mvs_tag_fifo
    import mat_vec_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_t push_data,
    input  logic    pop,
    output req_id_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    req_id_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mat_vec_sched.sv
// rtl/mat_vec_sched.sv - round-robin sharing of one mat_vec_mul between NREQ matrix-owning requesters
// Word/vector types come from mat_vec_sched_pkg; DATAWIDTH and NREQ overrides must match it.
module mat_vec_sched
    import mat_vec_sched_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int FRACBITS  = DEF_FRACBITS,
    parameter int NREQ      = DEF_NREQ,
    parameter int TAGDEPTH  = DEF_TAGDEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  vec4_t [NREQ-1:0]        req_x,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         out_valid,
    input  logic [NREQ-1:0]         out_ready,
    output vec4_t                   out_y,
    input  logic                    cfg_we,
    input  logic [$clog2(NREQ)-1:0] cfg_sel,
    input  logic [1:0]              cfg_row,
    input  logic [1:0]              cfg_col,
    input  logic [DATAWIDTH-1:0]    cfg_data,
    output logic                    busy
);

    mat4_t      bank_q [NREQ];
    req_id_t    rr_ptr_q, rr_ptr_d;
    req_id_t    grant, tag_head;
    int         idx;
    logic       grant_vld, issue, mm_en, mm_rstn, mm_o_dv;
    logic       tag_full, tag_empty, tag_pop;
    mat4_t      mm_a;
    vec4_t      mm_x, mm_y;

    always_comb begin
        grant     = rr_ptr_q;
        grant_vld = 1'b0;
        idx       = 0;
        // Walk downward so the requester closest to rr_ptr is the last (winning) assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (req_valid[req_id_t'(idx)]) begin
                grant     = req_id_t'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    assign mm_en   = ~(mm_o_dv & ~out_ready[tag_head]);
    assign issue   = grant_vld & mm_en & ~tag_full & ~rst;
    assign tag_pop = mm_o_dv & out_ready[tag_head] & ~tag_empty;
    assign mm_rstn = ~rst;

    always_comb begin
        req_ready = '0;
        mm_x      = '0;
        mm_a      = '0;
        rr_ptr_d  = rr_ptr_q;
        if (issue) begin
            req_ready[grant] = 1'b1;
            mm_x             = req_x[grant];
            mm_a             = bank_q[grant];
            rr_ptr_d         = (grant == req_id_t'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_comb begin
        out_valid = '0;
        if (mm_o_dv && !tag_empty) begin
            out_valid[tag_head] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // The issue path reads bank_q before this edge, so a same-cycle write is seen only by later issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                bank_q[i] <= identity_matrix();
            end
        end else if (cfg_we && (int'(cfg_sel) < NREQ)) begin
            bank_q[cfg_sel][cfg_row][cfg_col] <= cfg_data;
        end
    end

    mvs_tag_fifo #(
        .DEPTH     (TAGDEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (grant),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    mat_vec_mul #(
        .DATAWIDTH (DATAWIDTH),
        .FRACBITS  (FRACBITS)
    ) u_mat_vec_mul (
        .clk       (clk),
        .rstn      (mm_rstn),
        .i_enable  (mm_en),
        .i_dv      (issue),
        .i_A       (mm_a),
        .i_x       (mm_x),
        .o_dv      (mm_o_dv),
        .o_y       (mm_y)
    );

    assign out_y = mm_y;
    assign busy  = ~tag_empty;

    a_tag_never_full: assert property (@(posedge clk) disable iff (rst) !tag_full);
    a_result_has_tag: assert property (@(posedge clk) disable iff (rst) mm_o_dv |-> !tag_empty);

endmodule
